// File: rtl/jpeg_idct_transpose_ctrl.sv
// rtl/jpeg_idct_transpose_ctrl.sv - IDCT transpose buffer controller (row-major in, column-major out)
//
// Purpose:
//   Accepts one 8x8 block of 16-bit row-pass results in row-major order,
//   packs vertically adjacent row pairs into a 32x32 dual-port RAM, then
//   drains the block in column-major order towards the column pass.
//   A single buffer is held, so the fill and drain phases never overlap.
//
// Ports:
//   clk_i            clock (also clocks both RAM ports)
//   rst_i            asynchronous active-low reset
//   inport_valid_i   row-pass sample valid
//   inport_data_i    row-pass sample (16 bits)
//   inport_accept_o  sample taken when valid & accept
//   outport_valid_o  column-order sample valid
//   outport_data_o   column-order sample (16 bits)
//   outport_idx_o    original row-major index {row, col}
//   outport_last_o   final sample of the block (idx 63)
//   outport_accept_i downstream accept
//   ram_addr0_o      RAM port 0 write address {col, pair}
//   ram_data0_o      RAM port 0 write data {odd row, even row}
//   ram_wr0_o        RAM port 0 write enable
//   ram_addr1_o      RAM port 1 read address {col, pair}
//   ram_data1_i      RAM port 1 read data (one cycle latency)

module jpeg_idct_transpose_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inport_valid_i,
   input  logic [15:0] inport_data_i,
   output logic        inport_accept_o,
   output logic        outport_valid_o,
   output logic [15:0] outport_data_o,
   output logic [5:0]  outport_idx_o,
   output logic        outport_last_o,
   input  logic        outport_accept_i,
   output logic [4:0]  ram_addr0_o,
   output logic [31:0] ram_data0_o,
   output logic        ram_wr0_o,
   output logic [4:0]  ram_addr1_o,
   input  logic [31:0] ram_data1_i
);

   typedef enum logic [1:0] {
      ST_FILL,
      ST_READ,
      ST_LOW,
      ST_HIGH
   } state_t;

   state_t            state_q, state_d;
   logic [5:0]        n_q, n_d;
   logic [7:0][15:0]  row_buf_q, row_buf_d;
   logic              wr_q, wr_d;
   logic [4:0]        waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [2:0]        dcol_q, dcol_d;
   logic [1:0]        dpair_q, dpair_d;

   logic [2:0]        fill_row;
   logic [2:0]        fill_col;
   logic              drain_end;

   assign fill_row  = n_q[5:3];
   assign fill_col  = n_q[2:0];
   assign drain_end = (dcol_q == 3'd7) && (dpair_q == 2'd3);

   // The read address is held through READ/LOW/HIGH; since no writes land
   // on the word being drained, the RAM keeps presenting the same data.
   assign ram_addr1_o    = {dcol_q, dpair_q};
   assign ram_wr0_o      = wr_q;
   assign ram_addr0_o    = waddr_q;
   assign ram_data0_o    = wdata_q;
   assign outport_data_o = (state_q == ST_HIGH) ? ram_data1_i[31:16] : ram_data1_i[15:0];
   assign outport_idx_o  = {dpair_q, (state_q == ST_HIGH), dcol_q};

   always_comb begin
      state_d         = state_q;
      n_d             = n_q;
      row_buf_d       = row_buf_q;
      wr_d            = 1'b0;
      waddr_d         = waddr_q;
      wdata_d         = wdata_q;
      dcol_d          = dcol_q;
      dpair_d         = dpair_q;
      inport_accept_o = 1'b0;
      outport_valid_o = 1'b0;
      outport_last_o  = 1'b0;

      case (state_q)
         ST_FILL: begin
            inport_accept_o = 1'b1;
            if (inport_valid_i) begin
               n_d = n_q + 6'd1;
               if (!fill_row[0]) begin
                  // Even row: park the sample until its odd partner arrives.
                  row_buf_d[fill_col] = inport_data_i;
               end else begin
                  wr_d    = 1'b1;
                  waddr_d = {fill_col, fill_row[2:1]};
                  wdata_d = {inport_data_i, row_buf_q[fill_col]};
               end
               // The write for sample 63 lands during the first READ cycle;
               // it targets word 31, never the word 0 being read then.
               if (n_q == 6'd63) begin
                  state_d = ST_READ;
               end
            end
         end

         ST_READ: begin
            state_d = ST_LOW;
         end

         ST_LOW: begin
            outport_valid_o = 1'b1;
            if (outport_accept_i) begin
               state_d = ST_HIGH;
            end
         end

         ST_HIGH: begin
            outport_valid_o = 1'b1;
            outport_last_o  = drain_end;
            if (outport_accept_i) begin
               if (drain_end) begin
                  state_d = ST_FILL;
                  n_d     = 6'd0;
                  dcol_d  = 3'd0;
                  dpair_d = 2'd0;
               end else begin
                  // dpair is the low digit: walk down a column first.
                  {dcol_d, dpair_d} = {dcol_q, dpair_q} + 5'd1;
                  state_d           = ST_READ;
               end
            end
         end

         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= ST_FILL;
         n_q       <= 6'd0;
         row_buf_q <= '0;
         wr_q      <= 1'b0;
         waddr_q   <= 5'd0;
         wdata_q   <= 32'd0;
         dcol_q    <= 3'd0;
         dpair_q   <= 2'd0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         row_buf_q <= row_buf_d;
         wr_q      <= wr_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         dcol_q    <= dcol_d;
         dpair_q   <= dpair_d;
      end
   end

endmodule

// File: tb/tb_jpeg_idct_transpose_ctrl.sv
// tb/tb_jpeg_idct_transpose_ctrl.sv - self-checking bench for jpeg_idct_transpose_ctrl
//
// Purpose:
//   Drives blocks of ramp samples with random input gaps and output
//   backpressure, models the transpose RAM, and compares outputs and RAM
//   writes against a block-level model of the transpose.
//
// Ports: none (top-level bench).

module tb_jpeg_idct_transpose_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        inport_valid_i = 1'b0;
   logic [15:0] inport_data_i = 16'd0;
   logic        inport_accept_o;
   logic        outport_valid_o;
   logic [15:0] outport_data_o;
   logic [5:0]  outport_idx_o;
   logic        outport_last_o;
   logic        outport_accept_i = 1'b0;
   logic [4:0]  ram_addr0_o;
   logic [31:0] ram_data0_o;
   logic        ram_wr0_o;
   logic [4:0]  ram_addr1_o;
   logic [31:0] ram_data1_i;

   jpeg_idct_transpose_ctrl dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .inport_valid_i   (inport_valid_i),
      .inport_data_i    (inport_data_i),
      .inport_accept_o  (inport_accept_o),
      .outport_valid_o  (outport_valid_o),
      .outport_data_o   (outport_data_o),
      .outport_idx_o    (outport_idx_o),
      .outport_last_o   (outport_last_o),
      .outport_accept_i (outport_accept_i),
      .ram_addr0_o      (ram_addr0_o),
      .ram_data0_o      (ram_data0_o),
      .ram_wr0_o        (ram_wr0_o),
      .ram_addr1_o      (ram_addr1_o),
      .ram_data1_i      (ram_data1_i)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Transpose RAM: port 0 writes, port 1 registered read.
   logic [31:0] mem [0:31];
   always @(posedge clk_i) begin
      if (ram_wr0_o) mem[ram_addr0_o] <= ram_data0_o;
      ram_data1_i <= mem[ram_addr1_o];
   end

   int checks = 0;
   int passed = 0;

   logic [15:0] o_data [$];
   logic [5:0]  o_idx  [$];
   logic        o_last [$];
   int          o_cyc  [$];
   logic [4:0]  w_addr [$];
   logic [31:0] w_data [$];
   int          w_cyc  [$];
   int          acc_cyc [$];
   int          first_valid_cyc;
   int          stall_viol;
   int          inacc_viol;
   bit          timed_out;

   // Model: k-th output in column-major order is element (row=k%8, col=k/8),
   // i.e. row-major index (k%8)*8 + k/8, carrying the sample sent at that index.
   function automatic logic [22:0] model_out(input logic [15:0] base, input int k);
      logic [5:0] idx;
      idx = 6'((k % 8) * 8 + k / 8);
      return {base + 16'(idx), idx, (k == 63)};
   endfunction

   // Model: j-th write pairs odd-row sample m with the sample one row above it,
   // stored at word {col, row/2}.
   function automatic logic [36:0] model_wr(input logic [15:0] base, input int j, output int m);
      m = (j / 8) * 16 + 8 + (j % 8);
      return {5'((m % 8) * 4 + (m / 8) / 2), base + 16'(m), base + 16'(m - 8)};
   endfunction

   task automatic apply_reset();
      rst_i            = 1'b0;
      inport_valid_i   = 1'b0;
      outport_accept_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   // Drives one block (vpct/apct = percent chance of valid/accept per cycle)
   // and records everything seen until max_out outputs have been taken.
   task automatic run_block(input logic [15:0] base, input int vpct, input int apct, input int max_out);
      int          n_in;
      int          budget;
      bit          done;
      bit          prev_stall;
      logic [22:0] prev_out;
      o_data.delete(); o_idx.delete(); o_last.delete(); o_cyc.delete();
      w_addr.delete(); w_data.delete(); w_cyc.delete(); acc_cyc.delete();
      first_valid_cyc = -1;
      stall_viol      = 0;
      inacc_viol      = 0;
      timed_out       = 1'b0;
      n_in            = 0;
      budget          = 0;
      done            = 1'b0;
      prev_stall      = 1'b0;
      prev_out        = '0;
      while (!done) begin
         @(negedge clk_i);
         if (ram_wr0_o) begin
            w_addr.push_back(ram_addr0_o);
            w_data.push_back(ram_data0_o);
            w_cyc.push_back(cyc);
         end
         if (prev_stall && (!outport_valid_o ||
             {outport_data_o, outport_idx_o, outport_last_o} !== prev_out))
            stall_viol++;
         if (outport_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (inport_accept_o && n_in == 64) inacc_viol++;

         inport_valid_i = (n_in < 64) && ($urandom_range(99) < vpct);
         inport_data_i  = inport_valid_i ? base + 16'(n_in) : 16'($urandom);
         if (inport_valid_i && inport_accept_o) begin
            acc_cyc.push_back(cyc);
            n_in++;
         end

         outport_accept_i = ($urandom_range(99) < apct);
         if (outport_valid_o && outport_accept_i) begin
            o_data.push_back(outport_data_o);
            o_idx.push_back(outport_idx_o);
            o_last.push_back(outport_last_o);
            o_cyc.push_back(cyc);
            if (outport_last_o || o_data.size() == max_out) done = 1'b1;
         end
         prev_stall = outport_valid_o && !outport_accept_i;
         prev_out   = {outport_data_o, outport_idx_o, outport_last_o};
         budget++;
         if (budget > 3000) begin
            timed_out = 1'b1;
            done      = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++; if (inport_accept_o !== 1'b1) $display("FAIL reset_accept got %b exp 1", inport_accept_o); else passed++;
      checks++; if (outport_valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", outport_valid_o); else passed++;
      checks++; if (outport_last_o !== 1'b0) $display("FAIL reset_last got %b exp 0", outport_last_o); else passed++;
      checks++; if (outport_idx_o !== 6'd0) $display("FAIL reset_idx got %0d exp 0", outport_idx_o); else passed++;
      checks++; if (ram_wr0_o !== 1'b0) $display("FAIL reset_wr0 got %b exp 0", ram_wr0_o); else passed++;
      checks++; if (ram_addr0_o !== 5'd0) $display("FAIL reset_addr0 got %0d exp 0", ram_addr0_o); else passed++;
      checks++; if (ram_data0_o !== 32'd0) $display("FAIL reset_data0 got %h exp 0", ram_data0_o); else passed++;
      checks++; if (ram_addr1_o !== 5'd0) $display("FAIL reset_addr1 got %0d exp 0", ram_addr1_o); else passed++;
   endtask

   task automatic test_ramp();
      int          t0;
      int          m;
      logic [36:0] ew;
      run_block(16'h0100, 100, 100, 64);
      t0 = acc_cyc.size() > 0 ? acc_cyc[0] : 0;
      checks++; if (timed_out) $display("FAIL ramp_timeout got timeout exp completion"); else passed++;
      checks++; if (o_data.size() !== 64) $display("FAIL ramp_count got %0d exp 64", o_data.size()); else passed++;
      for (int k = 0; k < 64 && k < o_data.size(); k++) begin
         checks++;
         if ({o_data[k], o_idx[k], o_last[k]} !== model_out(16'h0100, k))
            $display("FAIL ramp_out[%0d] got %h exp %h", k, {o_data[k], o_idx[k], o_last[k]}, model_out(16'h0100, k));
         else passed++;
      end
      checks++; if (first_valid_cyc - t0 !== 65) $display("FAIL ramp_first_valid_cycle got %0d exp 65", first_valid_cyc - t0); else passed++;
      if (o_cyc.size() == 64) begin
         checks++; if (o_cyc[63] - t0 !== 159) $display("FAIL ramp_last_cycle got %0d exp 159", o_cyc[63] - t0); else passed++;
      end
      checks++; if (w_data.size() !== 32) $display("FAIL ramp_write_count got %0d exp 32", w_data.size()); else passed++;
      for (int j = 0; j < 32 && j < w_data.size(); j++) begin
         ew = model_wr(16'h0100, j, m);
         checks++;
         if ({w_addr[j], w_data[j]} !== ew || w_cyc[j] !== acc_cyc[m] + 1)
            $display("FAIL ramp_write[%0d] got %h@%0d exp %h@%0d", j, {w_addr[j], w_data[j]}, w_cyc[j] - t0, ew, acc_cyc[m] + 1 - t0);
         else passed++;
      end
      if (w_data.size() == 32) begin
         checks++; if ({w_addr[0], w_data[0], 32'(w_cyc[0] - t0)} !== {5'd0, 32'h01080100, 32'd9})
            $display("FAIL ramp_write_first got %0d/%h@%0d exp 0/01080100@9", w_addr[0], w_data[0], w_cyc[0] - t0); else passed++;
         checks++; if ({w_addr[1], w_data[1], 32'(w_cyc[1] - t0)} !== {5'd4, 32'h01090101, 32'd10})
            $display("FAIL ramp_write_second got %0d/%h@%0d exp 4/01090101@10", w_addr[1], w_data[1], w_cyc[1] - t0); else passed++;
         checks++; if ({w_addr[31], w_data[31], 32'(w_cyc[31] - t0)} !== {5'd31, 32'h013F0137, 32'd64})
            $display("FAIL ramp_write_last got %0d/%h@%0d exp 31/013F0137@64", w_addr[31], w_data[31], w_cyc[31] - t0); else passed++;
      end
      @(negedge clk_i);
      checks++; if (inport_accept_o !== 1'b1) $display("FAIL ramp_accept_at_160 got %b exp 1", inport_accept_o); else passed++;
      checks++; if (outport_valid_o !== 1'b0) $display("FAIL ramp_valid_at_160 got %b exp 0", outport_valid_o); else passed++;
      inport_valid_i = 1'b0;
   endtask

   task automatic test_backpressure();
      run_block(16'h0100, 100, 30, 64);
      checks++; if (timed_out) $display("FAIL bp_timeout got timeout exp completion"); else passed++;
      checks++; if (o_data.size() !== 64) $display("FAIL bp_count got %0d exp 64", o_data.size()); else passed++;
      for (int k = 0; k < 64 && k < o_data.size(); k++) begin
         checks++;
         if ({o_data[k], o_idx[k], o_last[k]} !== model_out(16'h0100, k))
            $display("FAIL bp_out[%0d] got %h exp %h", k, {o_data[k], o_idx[k], o_last[k]}, model_out(16'h0100, k));
         else passed++;
      end
      checks++; if (stall_viol !== 0) $display("FAIL bp_stall_stable got %0d changes exp 0", stall_viol); else passed++;
      checks++; if (inacc_viol !== 0) $display("FAIL bp_inport_accept_during_drain got %0d cycles exp 0", inacc_viol); else passed++;
   endtask

   task automatic test_input_gaps();
      int          m;
      logic [36:0] ew;
      run_block(16'h0100, 50, 100, 64);
      checks++; if (timed_out) $display("FAIL gaps_timeout got timeout exp completion"); else passed++;
      checks++; if (o_data.size() !== 64) $display("FAIL gaps_count got %0d exp 64", o_data.size()); else passed++;
      for (int k = 0; k < 64 && k < o_data.size(); k++) begin
         checks++;
         if ({o_data[k], o_idx[k], o_last[k]} !== model_out(16'h0100, k))
            $display("FAIL gaps_out[%0d] got %h exp %h", k, {o_data[k], o_idx[k], o_last[k]}, model_out(16'h0100, k));
         else passed++;
      end
      checks++; if (w_data.size() !== 32) $display("FAIL gaps_write_count got %0d exp 32", w_data.size()); else passed++;
      for (int j = 0; j < 32 && j < w_data.size(); j++) begin
         ew = model_wr(16'h0100, j, m);
         checks++;
         if ({w_addr[j], w_data[j]} !== ew || w_cyc[j] !== acc_cyc[m] + 1)
            $display("FAIL gaps_write[%0d] got %h@%0d exp %h@%0d", j, {w_addr[j], w_data[j]}, w_cyc[j], ew, acc_cyc[m] + 1);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      int last_first;
      run_block(16'h0100, 100, 100, 64);
      checks++; if (o_cyc.size() !== 64) $display("FAIL b2b_first_count got %0d exp 64", o_cyc.size()); else passed++;
      last_first = o_cyc.size() > 0 ? o_cyc[o_cyc.size() - 1] : 0;
      run_block(16'h0200, 100, 100, 64);
      checks++; if (o_data.size() !== 64) $display("FAIL b2b_second_count got %0d exp 64", o_data.size()); else passed++;
      for (int k = 0; k < 64 && k < o_data.size(); k++) begin
         checks++;
         if ({o_data[k], o_idx[k], o_last[k]} !== model_out(16'h0200, k))
            $display("FAIL b2b_out[%0d] got %h exp %h", k, {o_data[k], o_idx[k], o_last[k]}, model_out(16'h0200, k));
         else passed++;
      end
      if (acc_cyc.size() > 0) begin
         checks++; if (acc_cyc[0] !== last_first + 1)
            $display("FAIL b2b_gap got %0d cycles exp 1", acc_cyc[0] - last_first); else passed++;
      end
   endtask

   task automatic test_reset_mid_fill();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         inport_valid_i = 1'b1;
         inport_data_i  = 16'hBE00 + 16'(i);
      end
      @(negedge clk_i);
      inport_valid_i = 1'b0;
      rst_i          = 1'b0;
      #1;
      checks++; if (ram_wr0_o !== 1'b0) $display("FAIL fillrst_wr0 got %b exp 0", ram_wr0_o); else passed++;
      checks++; if (inport_accept_o !== 1'b1) $display("FAIL fillrst_accept got %b exp 1", inport_accept_o); else passed++;
      @(negedge clk_i);
      rst_i = 1'b1;
      run_block(16'h0400, 100, 100, 64);
      checks++; if (o_data.size() !== 64) $display("FAIL fillrst_count got %0d exp 64", o_data.size()); else passed++;
      for (int k = 0; k < 64 && k < o_data.size(); k++) begin
         checks++;
         if ({o_data[k], o_idx[k], o_last[k]} !== model_out(16'h0400, k))
            $display("FAIL fillrst_out[%0d] got %h exp %h", k, {o_data[k], o_idx[k], o_last[k]}, model_out(16'h0400, k));
         else passed++;
      end
   endtask

   task automatic test_reset_mid_drain();
      run_block(16'h0100, 100, 100, 20);
      checks++; if (o_data.size() !== 20) $display("FAIL drainrst_pre_count got %0d exp 20", o_data.size()); else passed++;
      rst_i = 1'b0;
      #1;
      checks++; if (outport_valid_o !== 1'b0) $display("FAIL drainrst_valid got %b exp 0", outport_valid_o); else passed++;
      checks++; if (inport_accept_o !== 1'b1) $display("FAIL drainrst_accept got %b exp 1", inport_accept_o); else passed++;
      checks++; if (ram_addr1_o !== 5'd0) $display("FAIL drainrst_addr1 got %0d exp 0", ram_addr1_o); else passed++;
      @(negedge clk_i);
      checks++; if (outport_valid_o !== 1'b0) $display("FAIL drainrst_valid_held got %b exp 0", outport_valid_o); else passed++;
      @(negedge clk_i);
      rst_i = 1'b1;
      run_block(16'h0300, 100, 100, 64);
      checks++; if (o_data.size() !== 64) $display("FAIL drainrst_count got %0d exp 64", o_data.size()); else passed++;
      for (int k = 0; k < 64 && k < o_data.size(); k++) begin
         checks++;
         if ({o_data[k], o_idx[k], o_last[k]} !== model_out(16'h0300, k))
            $display("FAIL drainrst_out[%0d] got %h exp %h", k, {o_data[k], o_idx[k], o_last[k]}, model_out(16'h0300, k));
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_backpressure();
      test_input_gaps();
      test_back_to_back();
      test_reset_mid_fill();
      test_reset_mid_drain();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/jpeg_idct_transpose_ctrl.md
# jpeg_idct_transpose_ctrl

Controls the IDCT transpose stage: accepts one 8x8 block of 16-bit row-pass results in row-major order, packs row pairs into the 32x32 dual-port transpose RAM, then reads them back in column-major order for the column pass. It sits between the IDCT row pass and the IDCT column pass. It drives RAM port 0 for writes and port 1 for reads; port 1's write enable is tied low at integration. The block holds a single buffer, so fill and drain phases do not overlap.

## Interface
Parameters: none.
- clk_i  in  1  clock; also drives the RAM's clk0_i/clk1_i.
- rst_i  in  1  reset, asynchronous, active-low.
- inport_valid_i  in  1  row-pass sample valid.
- inport_data_i  in  16  row-pass sample.
- inport_accept_o  out  1  sample accepted when valid & accept.
- outport_valid_o  out  1  column-order sample valid.
- outport_data_o  out  16  sample.
- outport_idx_o  out  6  original row-major index {row[2:0], col[2:0]}.
- outport_last_o  out  1  final sample of block (idx 63).
- outport_accept_i  in  1  downstream accept.
- ram_addr0_o  out  5  write address.
- ram_data0_o  out  32  write data.
- ram_wr0_o  out  1  write enable.
- ram_addr1_o  out  5  read address.
- ram_data1_i  in  32  read data, registered by the RAM with 1-cycle latency.

## Operation
- RAM word address = {col[2:0], pair[1:0]}. The word holds rows 2*pair (bits [15:0]) and 2*pair+1 (bits [31:16]) of that column.
- FSM states: FILL, READ, LOW, HIGH. Reset state is FILL.
- **FILL:**
  - inport_accept_o = 1. A 6-bit fill counter n counts accepted samples, with row = n[5:3] and col = n[2:0].
  - Even row: row_buf[col] <= data, no RAM write.
  - Odd row: in the cycle after the accept, ram_wr0_o = 1, ram_addr0_o = {col, row[2:1]}, ram_data0_o = {data, row_buf[col]}. These outputs are registered.
  - Input gaps (valid low) stall the counter with no side effects.
  - On the accept of n=63, go to READ. The final write issues during that READ cycle. Its address {7,3} never equals the first read address {0,0}.
- **Drain:** 3-bit dcol and 2-bit dpair registers, with ram_addr1_o = {dcol, dpair}. The address is held stable through READ, LOW and HIGH.
  - READ: outport_valid_o = 0. Go to LOW next cycle.
  - LOW: valid = 1, data = ram_data1_i[15:0], idx = {dpair,0, dcol}. On accept, go to HIGH.
  - HIGH: valid = 1, data = ram_data1_i[31:16], idx = {dpair,1, dcol}.
    - On accept, increment {dcol, dpair} with dpair as the low digit, then go to READ.
    - After the accept of dcol=7, dpair=3: return to FILL and clear n, dcol and dpair.
- Output order: idx 0, 8, 16, …, 56, 1, 9, …, 63.
- outport_last_o = 1 only in HIGH with dcol=7, dpair=3.
- No RAM writes occur outside FILL and the single trailing READ cycle, so read data stays stable while held in LOW/HIGH.
- Output data, idx and last are stable while valid is high and accept is low.

## Timing
- Reset values: state FILL, inport_accept_o=1, outport_valid_o=0, outport_last_o=0, outport_idx_o=0, outport_data_o=don't-care (ram_data1_i slice), ram_wr0_o=0, ram_addr0_o=0, ram_data0_o=0, ram_addr1_o=0, n=0.
- Fill: 64 accept cycles minimum.
- Drain: 3 cycles per word (READ, LOW, HIGH) with downstream always accepting, so 96 cycles per block.
- With both sides continuous and the first input accepted in cycle 0:
  - READ at cycle 64.
  - First output valid at cycle 65.
  - Last output, accepted, at cycle 159.
  - inport_accept_o = 1 again at cycle 160.
- Backpressure extends LOW/HIGH indefinitely, with no loss or reordering.
- Reset asserted mid-fill or mid-drain:
  - All state returns to reset values immediately.
  - The partial block is discarded.
  - The next accepted sample is n=0.
  - RAM contents are not cleared; they are overwritten by the next fill.

## Test plan
- **Ramp block:** sample n = 0x0100+n, continuous valid and accept.
  - Outputs 0x0100, 0x0108, 0x0110, …, 0x0138, 0x0101, …, 0x013F, with idx matching the low byte.
  - outport_last_o only on 0x013F; first valid at cycle 65, last at cycle 159.
- **RAM write check:** same ramp.
  - Writes seen: addr 0 data 0x01080100 at cycle 9, addr 4 data 0x01090101 at cycle 10.
  - 32 writes total, last being addr 31 data 0x013F0137 at cycle 64.
- **Random backpressure:** outport_accept_i random at 30% high.
  - Same sequence as the ramp case.
  - data/idx/last never change while valid is high and accept is low.
  - inport_accept_o stays 0 until the last sample is accepted.
- **Input gaps:** inport_valid_i random at 50%.
  - Identical output sequence.
  - Write count stays 32, with no writes during gaps.
- **Back-to-back blocks:** two blocks with distinct ramps, 0x0100+n then 0x0200+n.
  - The second block's outputs are correct with no first-block data mixed in.
  - The second block's first accept occurs exactly 1 cycle after the first block's last output accept.
- **Reset mid-drain:** assert rst_i low after 20 outputs, then release and send block 0x0300+n.
  - outport_valid_o=0 and inport_accept_o=1 while in reset.
  - Following block outputs 0x0300, 0x0308, … correctly.
